// File: rtl/npu_mem_bank.sv
// Single-port NPU memory bank: bank-ID decode, zero-init sequencer after reset,
// read-valid strobe, optional output register. Optional parity: NPU_MEM_PARITY_EN.
module npu_mem_bank #(
  parameter int WIDTH    = 21,
  parameter int DEPTH    = 1024,
  parameter int MEMSEL_W = 6,
  parameter int REGSEL_W = 11,
  parameter int MEM_ADDR = 0,
  parameter int OUT_REG  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MEMSEL_W-1:0] mem_adr,
  input  logic [REGSEL_W-1:0] reg_adr,
  input  logic                we,
  input  logic                re,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_vld,
  output logic                init_busy,
  output logic                par_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef NPU_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  logic          in_range;
  logic          hit;
  logic          ready;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] din_word;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_word_reg;
  logic          rd_vld_reg;
  logic [MW-1:0] out_word;
  logic          out_vld;

  // Any set bit above the bank's address range makes the access a miss.
  generate
    if (REGSEL_W > AW) begin : g_range
      assign in_range = (reg_adr[REGSEL_W-1:AW] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign hit       = (mem_adr == MEMSEL_W'(MEM_ADDR)) && in_range;
  assign ready     = (state_reg == READY);
  assign init_busy = (state_reg == INIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      INIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == AW'(DEPTH - 1)) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = INIT;
    endcase
  end

`ifdef NPU_MEM_PARITY_EN
  assign din_word = {^din, din};
`else
  assign din_word = din;
`endif

  // The sequencer owns the write port during INIT; user accesses are ignored.
  assign wr_en   = !rst && (ready ? (hit && we) : 1'b1);
  assign wr_addr = ready ? reg_adr[AW-1:0] : cnt_reg;
  assign wr_word = ready ? din_word : '0;
  assign rd_en   = ready && hit && re;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Separate read process gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word_reg <= '0;
      rd_vld_reg  <= 1'b0;
    end else begin
      rd_vld_reg <= rd_en;
      if (rd_en) rd_word_reg <= mem[reg_adr[AW-1:0]];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [MW-1:0] out_word_reg;
      logic          out_vld_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_word_reg <= '0;
          out_vld_reg  <= 1'b0;
        end else begin
          out_vld_reg <= rd_vld_reg;
          if (rd_vld_reg) out_word_reg <= rd_word_reg;
        end
      end

      assign out_word = out_word_reg;
      assign out_vld  = out_vld_reg;
    end else begin : g_out_direct
      assign out_word = rd_word_reg;
      assign out_vld  = rd_vld_reg;
    end
  endgenerate

  assign dout     = out_word[WIDTH-1:0];
  assign dout_vld = out_vld;

`ifdef NPU_MEM_PARITY_EN
  assign par_err = out_vld && ((^out_word[WIDTH-1:0]) != out_word[WIDTH]);
`else
  assign par_err = 1'b0;
`endif

endmodule
